pwxc_pair_scheduler: RTL and testbench

- Sequences one shared `cross_correlation_valid` datapath over every channel pair of a multi-channel BCI sample buffer.
- For each pair it:
  - pulses the correlator reset,
  - streams M samples of channel a on the A port, then N samples of channel b on the B port,
  - collects the M-N+1 lag results and tags each with (pair, lag).
- Results pass through a small output FIFO to a ready/valid consumer.
- Sits between the channel sample RAM and the feature-extraction stage.

---
 rtl/pwxc_pair_scheduler_if.sv | 34 +++
 rtl/pwxc_pair_scheduler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_pwxc_pair_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwxc_pair_scheduler_if.sv
// Result stream from the pair scheduler to the feature-extraction consumer.
//   res_valid : FIFO head holds a result
//   res_ready : consumer accepts the head this cycle
//   res_data  : correlation value
//   res_ch_a  : channel streamed on the A port
//   res_ch_b  : channel streamed on the B port
//   res_lag   : lag index within the pair
interface pwxc_pair_scheduler_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned M          = 64,
  parameter int unsigned N          = 32,
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned NRES  = M - N + 1;
  localparam int unsigned LAG_W = (NRES > 1) ? $clog2(NRES) : 1;

  logic                           res_valid;
  logic                           res_ready;
  logic signed [2*DATA_WIDTH-1:0] res_data;
  logic [CH_W-1:0]                res_ch_a;
  logic [CH_W-1:0]                res_ch_b;
  logic [LAG_W-1:0]               res_lag;

  modport master (
    output res_valid, res_data, res_ch_a, res_ch_b, res_lag,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_data, res_ch_a, res_ch_b, res_lag,
    output res_ready
  );
endinterface

// File: rtl/pwxc_pair_scheduler.sv
// Pair scheduler for a shared cross-correlation datapath. For every channel
// pair it resets the correlator, primes it, streams M samples of channel a
// on the A port then N samples of channel b on the B port, and collects the
// M-N+1 lag results into a small output FIFO tagged with (a, b, lag).
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start / busy / done : sweep control and status
//   rd_en/rd_ch/rd_addr : sample RAM read request (data returns next cycle)
//   rd_data             : sample RAM read data
//   xc_reset, xc_valid_a/b, xc_a/b : correlator drive (xc_reset includes reset)
//   xc_valid_out, xc_corr          : correlator result
//   res (interface)     : ready/valid result stream
//   err_overflow        : sticky, a result was dropped on a full FIFO
//   err_timeout         : sticky, a pair was abandoned waiting for results
//
// Build option: define PWXC_AUTOCORR_EN to include the a==b pairs.
module pwxc_pair_scheduler #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned M          = 64,
  parameter int unsigned N          = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 4096,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned ADDR_W    = (M > 1) ? $clog2(M) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_en,
  output logic [CH_W-1:0]                rd_ch,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic signed [DATA_WIDTH-1:0]   rd_data,
  output logic                           xc_reset,
  output logic                           xc_valid_a,
  output logic                           xc_valid_b,
  output logic signed [DATA_WIDTH-1:0]   xc_a,
  output logic signed [DATA_WIDTH-1:0]   xc_b,
  input  logic                           xc_valid_out,
  input  logic signed [2*DATA_WIDTH-1:0] xc_corr,
  pwxc_pair_scheduler_if.master          res,
  output logic                           err_overflow,
  output logic                           err_timeout
);

  localparam int unsigned NRES   = M - N + 1;
  localparam int unsigned LAG_W  = (NRES > 1) ? $clog2(NRES) : 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  // Offset of the first b channel relative to a: 0 includes the diagonal.
`ifdef PWXC_AUTOCORR_EN
  localparam int unsigned B_OFF = 0;
`else
  localparam int unsigned B_OFF = 1;
`endif
  localparam int unsigned A_LAST = NUM_CH - 1 - B_OFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XRST,
    S_PRIME,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT_RES,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            st, st_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [CH_W-1:0]   pa, pa_d, pb, pb_d;
  logic [LAG_W-1:0]  lag, lag_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              clr_err_c, set_tmo_c, push_c;
  logic              xrst_pulse;
  logic              pend_a, pend_b;

  // FIFO storage and pointers
  logic signed [2*DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
  logic [CH_W-1:0]                f_ch_a [FIFO_DEPTH];
  logic [CH_W-1:0]                f_ch_b [FIFO_DEPTH];
  logic [LAG_W-1:0]               f_lag  [FIFO_DEPTH];
  logic [PTR_W-1:0]               wp, rp;
  logic [CNT_W-1:0]               f_cnt;
  logic                           full_c, pop_c, wr_c;

  assign xc_reset = reset | xrst_pulse;

  // Next-state and per-pair bookkeeping
  always_comb begin
    st_d      = st;
    cnt_d     = cnt;
    pa_d      = pa;
    pb_d      = pb;
    lag_d     = lag;
    wait_d    = wait_cnt;
    clr_err_c = 1'b0;
    set_tmo_c = 1'b0;
    push_c    = 1'b0;
    case (st)
      S_IDLE: begin
        if (start) begin
          st_d      = S_XRST;
          pa_d      = '0;
          pb_d      = CH_W'(B_OFF);
          clr_err_c = 1'b1;
        end
      end
      S_XRST:  st_d = S_PRIME;
      S_PRIME: begin
        st_d  = S_LOAD_A;
        cnt_d = '0;
      end
      S_LOAD_A: begin
        if (cnt == ADDR_W'(M - 1)) begin
          st_d  = S_LOAD_B;
          cnt_d = '0;
        end else begin
          cnt_d = cnt + ADDR_W'(1);
        end
      end
      S_LOAD_B: begin
        if (cnt == ADDR_W'(N - 1)) begin
          st_d   = S_WAIT_RES;
          cnt_d  = '0;
          lag_d  = '0;
          wait_d = '0;
        end else begin
          cnt_d = cnt + ADDR_W'(1);
        end
      end
      S_WAIT_RES: begin
        wait_d = wait_cnt + WAIT_W'(1);
        if (xc_valid_out) begin
          push_c = 1'b1;
          lag_d  = lag + LAG_W'(1);
        end
        if (xc_valid_out && (lag == LAG_W'(NRES - 1))) begin
          st_d = S_NEXT;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          st_d      = S_NEXT;
          set_tmo_c = 1'b1;
        end
      end
      S_NEXT: begin
        if (pb == CH_W'(NUM_CH - 1)) begin
          if (pa == CH_W'(A_LAST)) begin
            st_d = S_DONE;
          end else begin
            pa_d = pa + CH_W'(1);
            pb_d = pa + CH_W'(1 + B_OFF);
            st_d = S_XRST;
          end
        end else begin
          pb_d = pb + CH_W'(1);
          st_d = S_XRST;
        end
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // State register; outputs are decoded from the next state so they line
  // up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_IDLE;
      cnt         <= '0;
      pa          <= '0;
      pb          <= '0;
      lag         <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      xrst_pulse  <= 1'b0;
      rd_en       <= 1'b0;
      rd_ch       <= '0;
      rd_addr     <= '0;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      xc_valid_a  <= 1'b0;
      xc_valid_b  <= 1'b0;
      xc_a        <= '0;
      xc_b        <= '0;
      err_timeout <= 1'b0;
    end else begin
      st         <= st_d;
      cnt        <= cnt_d;
      pa         <= pa_d;
      pb         <= pb_d;
      lag        <= lag_d;
      wait_cnt   <= wait_d;
      busy       <= (st_d != S_IDLE);
      done       <= (st_d == S_DONE);
      xrst_pulse <= (st_d == S_XRST);
      rd_en      <= (st_d == S_LOAD_A) || (st_d == S_LOAD_B);
      rd_ch      <= (st_d == S_LOAD_B) ? pb_d : ((st_d == S_LOAD_A) ? pa_d : '0);
      rd_addr    <= ((st_d == S_LOAD_A) || (st_d == S_LOAD_B)) ? cnt_d : '0;
      // RAM data lands the cycle after the read; it is registered onto the
      // correlator port one cycle later.
      pend_a     <= (st == S_LOAD_A);
      pend_b     <= (st == S_LOAD_B);
      // The prime strobe carries a zero sample the correlator discards.
      xc_valid_a <= pend_a || (st_d == S_PRIME);
      xc_a       <= pend_a ? rd_data : '0;
      xc_valid_b <= pend_b;
      xc_b       <= pend_b ? rd_data : '0;
      if (clr_err_c) begin
        err_timeout <= 1'b0;
      end else if (set_tmo_c) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Output FIFO: a push on a full FIFO only succeeds when a pop frees a slot.
  assign full_c = (f_cnt == CNT_W'(FIFO_DEPTH));
  assign pop_c  = (f_cnt != '0) && res.res_ready;
  assign wr_c   = push_c && (!full_c || pop_c);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp           <= '0;
      rp           <= '0;
      f_cnt        <= '0;
      err_overflow <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        f_data[i] <= '0;
        f_ch_a[i] <= '0;
        f_ch_b[i] <= '0;
        f_lag[i]  <= '0;
      end
    end else begin
      if (wr_c) begin
        f_data[wp] <= xc_corr;
        f_ch_a[wp] <= pa;
        f_ch_b[wp] <= pb;
        f_lag[wp]  <= lag;
        wp         <= ptr_inc(wp);
      end
      if (pop_c) begin
        rp <= ptr_inc(rp);
      end
      case ({wr_c, pop_c})
        2'b10:   f_cnt <= f_cnt + CNT_W'(1);
        2'b01:   f_cnt <= f_cnt - CNT_W'(1);
        default: f_cnt <= f_cnt;
      endcase
      if (clr_err_c) begin
        err_overflow <= 1'b0;
      end else if (push_c && full_c && !pop_c) begin
        err_overflow <= 1'b1;
      end
    end
  end

  assign res.res_valid = (f_cnt != '0);
  assign res.res_data  = f_data[rp];
  assign res.res_ch_a  = f_ch_a[rp];
  assign res.res_ch_b  = f_ch_b[rp];
  assign res.res_lag   = f_lag[rp];

endmodule

// File: tb/tb_pwxc_pair_scheduler.sv
// Bench for pwxc_pair_scheduler: behavioural sample RAM and correlator,
// result scoreboard fed at stimulus time and drained by the consumer.
module tb_pwxc_pair_scheduler;

`ifdef PWXC_AUTOCORR_EN
  localparam int NUM_CH = 2;
  localparam int B_OFF  = 0;
`else
  localparam int NUM_CH = 3;
  localparam int B_OFF  = 1;
`endif
  localparam int M    = 8;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int FD   = 4;
  localparam int TMO  = 4096;
  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(M);
  localparam int NRES = M - N + 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic                   busy, done, rd_en;
  logic [CH_W-1:0]        rd_ch;
  logic [AW-1:0]          rd_addr;
  logic signed [DW-1:0]   rd_data = '0;
  logic                   xc_reset, xc_valid_a, xc_valid_b;
  logic signed [DW-1:0]   xc_a, xc_b;
  logic                   xc_valid_out = 1'b0;
  logic signed [2*DW-1:0] xc_corr = '0;
  logic                   err_overflow, err_timeout;

  pwxc_pair_scheduler_if #(.NUM_CH(NUM_CH), .M(M), .N(N), .DATA_WIDTH(DW)) res_if ();

  pwxc_pair_scheduler #(
    .NUM_CH(NUM_CH), .M(M), .N(N), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .xc_reset(xc_reset), .xc_valid_a(xc_valid_a), .xc_valid_b(xc_valid_b),
    .xc_a(xc_a), .xc_b(xc_b), .xc_valid_out(xc_valid_out), .xc_corr(xc_corr),
    .res(res_if), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input int val, input int a, input int b, input int lag);
    logic [63:0] r;
    r = {val[31:0], a[7:0], b[7:0], lag[7:0]};
    return r;
  endfunction

  // Pair list in sweep order
  int pa_l[$];
  int pb_l[$];
  logic [63:0] exp_q[$];

  // Every sample of channel c is c+1, so each lag sums to N*(a+1)*(b+1).
  task automatic push_sweep(input int skip, input int maxn);
    int n = 0;
    for (int p = 0; p < pa_l.size(); p++) begin
      if (p != skip) begin
        for (int l = 0; l < NRES; l++) begin
          if (maxn < 0 || n < maxn)
            exp_q.push_back(pack(N * (pa_l[p] + 1) * (pb_l[p] + 1), pa_l[p], pb_l[p], l));
          n++;
        end
      end
    end
  endtask

  // Sample RAM: registered read
  always @(posedge clk) begin
    if (rd_en) rd_data <= DW'(int'(rd_ch) + 1);
  end

  // Behavioural correlator: discards the first A strobe after reset,
  // buffers M A and N B samples, then emits one lag per cycle.
  logic signed [DW-1:0] abuf [M];
  logic signed [DW-1:0] bbuf [N];
  int  na = 0, nb = 0, eidx = 0;
  bit  primed = 0, emit = 0;
  bit  sup_en = 0;
  int  sup_a = 0, sup_b = 0;

  function automatic logic signed [2*DW-1:0] corr(input int lag);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(abuf[lag + k]) * int'(bbuf[k]);
    return (2*DW)'(s);
  endfunction

  always @(posedge clk) begin
    if (xc_reset) begin
      primed <= 0; na <= 0; nb <= 0; emit <= 0; eidx <= 0;
      xc_valid_out <= 1'b0;
      xc_corr <= '0;
    end else begin
      xc_valid_out <= 1'b0;
      if (xc_valid_a) begin
        if (!primed) primed <= 1;
        else if (na < M) begin
          abuf[na] <= xc_a;
          na <= na + 1;
        end
      end
      if (xc_valid_b && nb < N) begin
        bbuf[nb] <= xc_b;
        nb <= nb + 1;
        if (nb == N - 1) begin
          emit <= 1;
          eidx <= 0;
        end
      end
      if (emit) begin
        if (!(sup_en && int'(abuf[0]) == sup_a + 1 && int'(bbuf[0]) == sup_b + 1)) begin
          xc_valid_out <= 1'b1;
          xc_corr <= corr(eidx);
        end
        if (eidx == M - N) emit <= 0;
        else eidx <= eidx + 1;
      end
    end
  end

  // Consumer and scoreboard
  always @(negedge clk) begin
    if (!reset && res_if.res_valid && res_if.res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("res", pack(int'(res_if.res_data), int'(res_if.res_ch_a),
                        int'(res_if.res_ch_b), int'(res_if.res_lag)), exp_q.pop_front());
      end
    end
  end

  // Done pulses, pair starts and per-pair strobe counts
  int  done_cnt = 0, pair_cnt = 0, va_cnt = 0, vb_cnt = 0;
  bit  cnt_en = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset && xc_reset) pair_cnt++;
    if (!cnt_en || reset) begin
      va_cnt = 0;
      vb_cnt = 0;
    end else begin
      if (xc_valid_a) va_cnt++;
      if (xc_valid_b) vb_cnt++;
      if ((xc_reset && (va_cnt != 0 || vb_cnt != 0)) || done) begin
        chk("va_per_pair", 64'(va_cnt), 64'(M + 1));
        chk("vb_per_pair", 64'(vb_cnt), 64'(N));
        va_cnt = 0;
        vb_cnt = 0;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 64'({busy, done, rd_en, rd_ch, rd_addr, xc_valid_a, xc_valid_b,
                            res_if.res_valid, err_overflow, err_timeout,
                            res_if.res_ch_a, res_if.res_ch_b, res_if.res_lag}), 64'd0);
    chk({tag, "_dat"}, {xc_a, xc_b, res_if.res_data}, 64'd0);
    chk({tag, "_xrst"}, 64'(xc_reset), 64'd1);
  endtask

  task automatic start_sweep(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    int d0;
    int p0;
    bit seen;
    for (int a = 0; a < NUM_CH; a++)
      for (int b = a + B_OFF; b < NUM_CH; b++) begin
        pa_l.push_back(a);
        pb_l.push_back(b);
      end
    res_if.res_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Full sweep, consumer always ready
    res_if.res_ready = 1'b1;
    push_sweep(-1, -1);
    d0 = done_cnt;
    start_sweep("t1");
    wait_done(d0, 2000);
    repeat (20) @(posedge clk);
    #1;
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t1_sb_left", 64'(exp_q.size()), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_errs", 64'({err_overflow, err_timeout}), 64'd0);

    // Consumer stalled: only the first FD results survive
    res_if.res_ready = 1'b0;
    push_sweep(-1, FD);
    d0 = done_cnt;
    start_sweep("t2");
    wait_done(d0, 2000);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t2_overflow", 64'(err_overflow), 64'd1);
    chk("t2_valid_held", 64'(res_if.res_valid), 64'd1);
    res_if.res_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t2_sb_left", 64'(exp_q.size()), 64'd0);
    chk("t2_drained", 64'(res_if.res_valid), 64'd0);

    // Second pair never answers
    sup_en = 1;
    sup_a  = pa_l[1];
    sup_b  = pb_l[1];
    push_sweep(1, -1);
    d0 = done_cnt;
    start_sweep("t3");
    chk("t3_ovf_cleared", 64'(err_overflow), 64'd0);
    wait_done(d0, 20000);
    repeat (20) @(posedge clk);
    #1;
    sup_en = 0;
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t3_timeout", 64'(err_timeout), 64'd1);
    chk("t3_sb_left", 64'(exp_q.size()), 64'd0);

    // Abort during the first B stream, then a clean sweep
    d0 = done_cnt;
    start_sweep("t4");
    chk("t4_tmo_cleared", 64'(err_timeout), 64'd0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (xc_valid_b) seen = 1;
    end
    chk("t4_load_b_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 check_zero("abort");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    push_sweep(-1, -1);
    d0 = done_cnt;
    start_sweep("t4b");
    wait_done(d0, 2000);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t4_sb_left", 64'(exp_q.size()), 64'd0);

    // start pulses while busy are ignored
    cnt_en = 1;
    push_sweep(-1, -1);
    d0 = done_cnt;
    p0 = pair_cnt;
    start_sweep("t5");
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0, 2000);
    repeat (20) @(posedge clk);
    #1;
    cnt_en = 0;
    chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t5_pairs", 64'(pair_cnt - p0), 64'(pa_l.size()));
    chk("t5_sb_left", 64'(exp_q.size()), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
